// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - enable/input/result bundle for the period meter
interface period_meter_if #(
  parameter int WIDTH = 24
);
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output enable, sig_in,
    input  period, high_time, valid, overflow, busy
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, valid, overflow, busy
  );
endinterface

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow async square wave in cin cycles
module period_meter #(
  parameter int               WIDTH     = 24,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic          cin,
  input  logic          rst,
  period_meter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEASURE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_cnt, r_hcnt;
  logic [WIDTH-1:0] r_period, r_high;
  logic             r_valid, r_overflow, r_busy;
  logic             w_rise;

  assign w_rise = r_s2 & ~r_s3;

  assign bus.period    = r_period;
  assign bus.high_time = r_high;
  assign bus.valid     = r_valid;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = r_busy;

  always_ff @(posedge cin) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_s1    <= bus.sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      // Disable beats everything, including a coincident rise.
      if (!bus.enable) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ARM;
          end
          ST_ARM: begin
            r_busy <= 1'b1;
            if (w_rise) begin
              r_cnt   <= ONE;
              r_hcnt  <= ONE;
              r_state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            r_busy <= 1'b1;
            if (w_rise) begin
              r_period   <= r_cnt;
              r_high     <= r_hcnt;
              r_valid    <= 1'b1;
              r_overflow <= 1'b0;
              r_cnt      <= ONE;
              r_hcnt     <= ONE;
            end else if (r_cnt == MAX_COUNT) begin
              r_overflow <= 1'b1;
              r_cnt      <= '0;
              r_hcnt     <= '0;
              r_state    <= ST_ARM;
            end else begin
              r_cnt  <= r_cnt + ONE;
              r_hcnt <= r_hcnt + {{(WIDTH-1){1'b0}}, r_s2};
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter (MAX_COUNT 50 and 20 instances)
module tb_period_meter;
  localparam int W = 24;

  logic cin = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sig_in = 1'b0;

  always #5 cin = ~cin;

  period_meter_if #(.WIDTH(W)) bus_a ();
  period_meter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.enable = enable;
  assign bus_a.sig_in = sig_in;
  assign bus_b.enable = enable;
  assign bus_b.sig_in = sig_in;

  period_meter #(.WIDTH(W), .MAX_COUNT(24'd50)) dut_a (.cin(cin), .rst(rst), .bus(bus_a));
  period_meter #(.WIDTH(W), .MAX_COUNT(24'd20)) dut_b (.cin(cin), .rst(rst), .bus(bus_b));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: a rise is seen two edges after the input was sampled high following a low sample;
  // period is the edge distance between rises, high time the count of high samples in between.
  bit     hist [0:4095];
  int     n = 0;
  int     mode [2];
  int     r1 [2];
  int     exp_p [2];
  int     exp_h [2];
  bit     exp_v [2];
  bit     exp_o [2];
  bit     exp_b [2];
  int     maxv [2] = '{50, 20};
  bit     model_ok = 1'b0;
  bit     rise_m;
  int     hsum;

  always @(posedge cin) begin
    hist[n] = rst ? 1'b0 : sig_in;
    rise_m = (n >= 3) && hist[n-2] && !hist[n-3];
    for (int k = 0; k < 2; k++) begin
      exp_v[k] = 1'b0;
      if (rst) begin
        mode[k] = 0; exp_p[k] = 0; exp_h[k] = 0; exp_o[k] = 1'b0; exp_b[k] = 1'b0;
      end else if (!enable) begin
        mode[k] = 0; exp_b[k] = 1'b0;
      end else if (mode[k] == 0) begin
        mode[k] = 1; exp_b[k] = 1'b1;
      end else if (mode[k] == 1) begin
        if (rise_m) begin mode[k] = 2; r1[k] = n; end
      end else begin
        if (rise_m) begin
          hsum = 0;
          for (int e = r1[k]; e < n; e++) hsum += hist[e-2];
          exp_p[k] = n - r1[k];
          exp_h[k] = hsum;
          exp_v[k] = 1'b1;
          exp_o[k] = 1'b0;
          r1[k] = n;
        end else if (n - r1[k] == maxv[k]) begin
          exp_o[k] = 1'b1;
          mode[k] = 1;
        end
      end
    end
    if (n < 4095) n++;
    model_ok = 1'b1;
  end

  always @(negedge cin) begin
    if (model_ok) begin
      chk("a_period",    bus_a.period,    exp_p[0]);
      chk("a_high_time", bus_a.high_time, exp_h[0]);
      chk("a_valid",     bus_a.valid,     exp_v[0]);
      chk("a_overflow",  bus_a.overflow,  exp_o[0]);
      chk("a_busy",      bus_a.busy,      exp_b[0]);
      chk("b_period",    bus_b.period,    exp_p[1]);
      chk("b_high_time", bus_b.high_time, exp_h[1]);
      chk("b_valid",     bus_b.valid,     exp_v[1]);
      chk("b_overflow",  bus_b.overflow,  exp_o[1]);
      chk("b_busy",      bus_b.busy,      exp_b[1]);
    end
  end

  int vcnt_a = 0;
  bit watch = 1'b0;
  int first_p = -1;

  always @(negedge cin) begin
    if (bus_a.valid) vcnt_a++;
    if (watch && bus_a.valid) begin
      first_p = bus_a.period;
      watch = 1'b0;
    end
  end

  task automatic drive(input bit v, input int c);
    sig_in = v;
    repeat (c) @(negedge cin);
  endtask

  task automatic wave(input int hi, input int lo, input int np);
    repeat (np) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  int v0;
  int vg;

  initial begin
    @(negedge cin);
    rst = 1'b1;
    enable = 1'b0;
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 1);
    #1;
    chk("rst_period",   bus_a.period,    0);
    chk("rst_high",     bus_a.high_time, 0);
    chk("rst_valid",    bus_a.valid,     0);
    chk("rst_overflow", bus_a.overflow,  0);
    chk("rst_busy",     bus_a.busy,      0);

    rst = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(negedge cin);
    enable = 1'b1;
    @(negedge cin);
    #1;
    chk("busy_after_enable", bus_a.busy, 1);

    v0 = vcnt_a;
    wave(5, 5, 6);
    #1;
    chk("sq_period",     bus_a.period,    10);
    chk("sq_high",       bus_a.high_time, 5);
    chk("sq_valid_cnt",  vcnt_a - v0,     5);
    chk("sq_b_period",   bus_b.period,    10);

    wave(3, 17, 3);
    #1;
    chk("asym_period",   bus_a.period,    20);
    chk("asym_high",     bus_a.high_time, 3);
    chk("asym_b_period", bus_b.period,    20);
    chk("asym_b_ovf",    bus_b.overflow,  0);

    wave(8, 8, 3);
    #1;
    chk("sym16_period",  bus_a.period,    16);
    chk("sym16_high",    bus_a.high_time, 8);

    drive(1'b1, 3);
    drive(1'b0, 60);
    #1;
    chk("tmo_overflow",  bus_a.overflow,  1);
    chk("tmo_period",    bus_a.period,    16);
    chk("tmo_busy",      bus_a.busy,      1);
    chk("tmo_b_ovf",     bus_b.overflow,  1);

    wave(6, 6, 3);
    #1;
    chk("post_tmo_period", bus_a.period,   12);
    chk("post_tmo_ovf",    bus_a.overflow, 0);
    chk("post_tmo_b_ovf",  bus_b.overflow, 0);

    wave(5, 5, 2);
    drive(1'b1, 5);
    drive(1'b0, 4);
    enable = 1'b0;
    vg = vcnt_a;
    drive(1'b0, 1);
    wave(5, 5, 1);
    chk("gap_valid_cnt", vcnt_a - vg, 0);
    enable = 1'b1;
    drive(1'b0, 3);
    first_p = -1;
    watch = 1'b1;
    wave(5, 5, 3);
    #1;
    chk("reen_first_period", first_p,      10);
    chk("reen_period",       bus_a.period, 10);

    wave(10, 10, 3);
    #1;
    chk("coin_b_period", bus_b.period,    20);
    chk("coin_b_high",   bus_b.high_time, 10);
    chk("coin_b_ovf",    bus_b.overflow,  0);
    chk("coin_a_period", bus_a.period,    20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
